// File: rtl/uart_slave_rx_if.sv
// Receive-side character stream: head-of-FIFO character with error flags,
// presented on a valid/ready handshake.
interface uart_slave_rx_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_parity_err;
  logic                  rx_frame_err;
  logic                  rx_valid;
  logic                  rx_ready;

  // The receiver sources characters; the consumer returns ready.
  modport master (
    output rx_data,
    output rx_parity_err,
    output rx_frame_err,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_parity_err,
    input  rx_frame_err,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_slave_rx.sv
// UART receiver for the slave end of the link: synchronizes rx, detects
// the start bit with an oversampling counter, shifts in LSB-first data,
// checks optional parity and one or two stop bits, and queues each
// character with its error flags in a small FIFO.
module uart_slave_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  input  logic [15:0]            baud_div,
  input  logic                   parity_en,
  input  logic                   parity_odd,
  input  logic                   stop_bits,
  uart_slave_rx_if.master        rx_if,
  output logic                   overrun,
  output logic                   busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t r_state, w_next;

  logic                  r_rx_meta, r_rx_s, r_rx_prev;
  logic [15:0]           r_div, r_baud_cnt;
  logic [SW-1:0]         r_samp_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_stop_cnt;
  logic                  r_par_en, r_par_odd, r_stop2;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_err, r_frame_err;
  logic                  r_overrun;

  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic                  r_mem_pe   [FIFO_DEPTH];
  logic                  r_mem_fe   [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_tick, w_bit_pt;
  logic w_start_det, w_start_ok, w_data_smp, w_par_smp, w_stop_smp, w_push;
  logic w_valid, w_full, w_pop, w_wr;
  logic w_par_err_new, w_frame_err_new;

  assign w_tick   = (r_state != S_IDLE) && (r_baud_cnt == (r_div - 16'd1));
  assign w_bit_pt = w_tick && (r_samp_cnt == SAMP_LAST);

  // Parity over data plus received parity bit must match the selected sense.
  assign w_par_err_new   = ((^r_shift) ^ r_rx_s) != r_par_odd;
  // The final stop sample is folded in so the push carries it this clk.
  assign w_frame_err_new = r_frame_err | ~r_rx_s;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state and per-clk action strobes.
  always_comb begin
    w_next      = r_state;
    w_start_det = 1'b0;
    w_start_ok  = 1'b0;
    w_data_smp  = 1'b0;
    w_par_smp   = 1'b0;
    w_stop_smp  = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_start_det = 1'b1;
          w_next      = S_START;
        end
      end
      S_START: begin
        if (w_tick && (r_samp_cnt == SAMP_MID)) begin
          if (!r_rx_s) begin
            w_start_ok = 1'b1;
            w_next     = S_DATA;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_bit_pt) begin
          w_data_smp = 1'b1;
          if (r_bit_cnt == BIT_LAST) w_next = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bit_pt) begin
          w_par_smp = 1'b1;
          w_next    = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_pt) begin
          w_stop_smp = 1'b1;
          if (!(r_stop2 && !r_stop_cnt)) begin
            w_push = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Frame datapath: config capture, baud/sample/bit counters, shift and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= 16'd1;
      r_baud_cnt  <= '0;
      r_samp_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_stop2     <= 1'b0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_start_det) begin
      r_div       <= (baud_div == 16'd0) ? 16'd1 : baud_div;
      r_par_en    <= parity_en;
      r_par_odd   <= parity_odd;
      r_stop2     <= stop_bits;
      r_baud_cnt  <= '0;
      r_samp_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (r_state != S_IDLE) begin
      r_baud_cnt <= w_tick ? 16'd0 : r_baud_cnt + 16'd1;
      if (w_start_ok)  r_samp_cnt <= '0;
      else if (w_tick) r_samp_cnt <= (r_samp_cnt == SAMP_LAST) ? '0 : r_samp_cnt + 1'b1;
      if (w_data_smp) begin
        r_shift   <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
        r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
      end
      if (w_par_smp) r_par_err <= w_par_err_new;
      if (w_stop_smp) begin
        r_frame_err <= w_frame_err_new;
        r_stop_cnt  <= 1'b1;
      end
    end
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = w_valid && rx_if.rx_ready;
  assign w_wr    = w_push && (!w_full || w_pop);

  // FIFO storage; contents only matter while counted as valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_data[r_wr_ptr] <= r_shift;
      r_mem_pe[r_wr_ptr]   <= r_par_err;
      r_mem_fe[r_wr_ptr]   <= w_frame_err_new;
    end
  end

  // FIFO pointers, occupancy and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overrun <= w_push && w_full && !w_pop;
    end
  end

  assign rx_if.rx_valid      = w_valid;
  assign rx_if.rx_data       = w_valid ? r_mem_data[r_rd_ptr] : '0;
  assign rx_if.rx_parity_err = w_valid ? r_mem_pe[r_rd_ptr]   : 1'b0;
  assign rx_if.rx_frame_err  = w_valid ? r_mem_fe[r_rd_ptr]   : 1'b0;
  assign overrun             = r_overrun;
  assign busy                = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_slave_rx.sv
// Directed bench for uart_slave_rx: baud_div=1, 16 clk per bit.
module tb_uart_slave_rx;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop_bits;
  logic        overrun, busy;
  int          checks;
  int          failures;
  int          ovr_cnt;

  uart_slave_rx_if #(.DATA_WIDTH(8)) u_if ();

  uart_slave_rx #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop_bits  (stop_bits),
    .rx_if      (u_if),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overrun pulse monitor.
  always @(posedge clk) if (overrun) ovr_cnt <= ovr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic s1, input logic s2, input logic two);
    logic [7:0] v;
    v = d;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    if (pe) send_bit(pb);
    send_bit(s1);
    if (two) send_bit(s2);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop();
    u_if.rx_ready = 1'b1;
    @(negedge clk);
    u_if.rx_ready = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    ovr_cnt    = 0;
    rst_n      = 1'b0;
    rx         = 1'b1;
    baud_div   = 16'd1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop_bits  = 1'b0;
    u_if.rx_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_valid",   u_if.rx_valid, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data",    u_if.rx_data, 0);
    chk("rst_pe",      u_if.rx_parity_err, 0);
    chk("rst_fe",      u_if.rx_frame_err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain 8N1 frame
    send_frame(8'hA5, 0, 0, 1, 1, 0);
    chk("a5_valid", u_if.rx_valid, 1);
    chk("a5_data",  u_if.rx_data, 32'hA5);
    chk("a5_pe",    u_if.rx_parity_err, 0);
    chk("a5_fe",    u_if.rx_frame_err, 0);
    chk("a5_busy",  busy, 0);
    pop();
    chk("a5_popped", u_if.rx_valid, 0);

    // Even parity, good then bad parity bit
    parity_en = 1'b1;
    send_frame(8'h07, 1, 1, 1, 1, 0);
    chk("par_ok_data", u_if.rx_data, 32'h07);
    chk("par_ok_pe",   u_if.rx_parity_err, 0);
    pop();
    send_frame(8'h07, 1, 0, 1, 1, 0);
    chk("par_bad_data", u_if.rx_data, 32'h07);
    chk("par_bad_pe",   u_if.rx_parity_err, 1);
    chk("par_bad_fe",   u_if.rx_frame_err, 0);
    pop();
    parity_en = 1'b0;

    // Framing errors
    send_frame(8'h3C, 0, 0, 0, 1, 0);
    chk("fe1_data", u_if.rx_data, 32'h3C);
    chk("fe1_fe",   u_if.rx_frame_err, 1);
    chk("fe1_pe",   u_if.rx_parity_err, 0);
    pop();
    stop_bits = 1'b1;
    send_frame(8'h81, 0, 0, 1, 0, 1);
    chk("fe2_data", u_if.rx_data, 32'h81);
    chk("fe2_fe",   u_if.rx_frame_err, 1);
    pop();
    send_frame(8'h81, 0, 0, 1, 1, 1);
    chk("two_stop_ok_fe", u_if.rx_frame_err, 0);
    pop();
    stop_bits = 1'b0;

    // Short glitch is a false start
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy_mid", busy, 1);
    repeat (30) @(negedge clk);
    chk("glitch_valid", u_if.rx_valid, 0);
    chk("glitch_busy",  busy, 0);

    // Overrun on fifth frame
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 0, 1, 1, 0);
    chk("ovr_four_valid", u_if.rx_valid, 1);
    chk("ovr_four_cnt",   ovr_cnt, 0);
    send_frame(8'h05, 0, 0, 1, 1, 0);
    chk("ovr_five_cnt", ovr_cnt, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_pop_data", u_if.rx_data, i);
      pop();
    end
    chk("ovr_empty", u_if.rx_valid, 0);

    // Reset in the middle of a frame with a character queued
    send_frame(8'h11, 0, 0, 1, 1, 0);
    chk("prereset_valid", u_if.rx_valid, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("prereset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_busy",  busy, 0);
    chk("reset_valid", u_if.rx_valid, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h66, 0, 0, 1, 1, 0);
    chk("post_reset_valid", u_if.rx_valid, 1);
    chk("post_reset_data",  u_if.rx_data, 32'h66);
    chk("post_reset_fe",    u_if.rx_frame_err, 0);
    pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_slave_rx.md
Name: uart_slave_rx

Overview:
- Synthesizable UART receiver for the slave end of the UART link.
- Recovers serial frames driven by the master transmit path: oversampled start detection, LSB-first data, optional parity, stop check.
- Buffers received characters with error flags in a small FIFO.
- Presents them on a valid/ready stream to the slave agent side of the testbench.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..8).
- OVERSAMPLE, 16, baud ticks per bit (even, >=8).
- FIFO_DEPTH, 4, received-character buffer entries (power of 2, >=2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- baud_div  input  16  clk cycles per baud tick; value 0 treated as 1
- parity_en  input  1  1 = parity bit present after data
- parity_odd  input  1  1 = odd parity, 0 = even
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits
- rx_data  output  DATA_WIDTH  head-of-FIFO character
- rx_parity_err  output  1  parity error flag of head character
- rx_frame_err  output  1  framing error flag of head character
- rx_valid  output  1  FIFO non-empty
- rx_ready  input  1  consumer accepts head when rx_valid && rx_ready
- overrun  output  1  one-clk pulse when a completed frame is dropped because the FIFO is full
- busy  output  1  receive FSM not in IDLE

Behaviour:
- Reset: rst_n low asynchronously clears FSM to IDLE and all counters and FIFO pointers. Outputs reset to 0: rx_valid, overrun, busy, rx_data, both error flags. Synchronizer flops reset to 1 (idle). A frame in progress is discarded.
- Config inputs (baud_div, parity_en, parity_odd, stop_bits) are sampled only in IDLE at start-edge detection and held for the whole frame.
- rx passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronized value rx_s.
- Baud tick counter:
  - Runs freely while not IDLE.
  - Counts 0..baud_div-1; tick asserts for one clk when count == baud_div-1, then the counter wraps to 0.
  - Counter is cleared on entry to START.
- Sample counter: 0..OVERSAMPLE-1, advances on tick.
- FSM states and transitions:
  - IDLE: on rx_s 1->0 go to START; clear tick and sample counters.
  - START: at sample count OVERSAMPLE/2-1 (mid-bit), if rx_s==0 clear sample counter and go to DATA; otherwise it is a false start, return to IDLE with no output.
  - DATA: every OVERSAMPLE ticks, sample rx_s into a shift register, LSB first. After DATA_WIDTH bits go to PARITY if parity_en, else STOP.
  - PARITY: sample once. parity_err = (XOR(data) ^ sampled bit) != parity_odd, i.e. even parity requires the total count of ones to be even.
  - STOP: sample each stop bit at mid-bit. Any stop sample == 0 sets frame_err. With stop_bits=1, both stop bits are checked.
  - After the last stop sample: write {data, parity_err, frame_err} to the FIFO on the same clk, then go to IDLE. Next-frame start detection is allowed from the following clk.
- Frame with frame_err is still stored.
- Latency: rx_valid rises one clk after the final stop-bit mid-sample tick when the FIFO was empty.
- FIFO:
  - Pop occurs when rx_valid && rx_ready.
  - Push when full with no pop in the same clk: frame is dropped, overrun pulses, FIFO contents are unchanged.
  - Push and pop in the same clk when full: both occur, no overrun.
  - Push and pop when empty: not possible, because rx_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- rx_data and the flags are 0 while rx_valid=0. Otherwise they are stable until popped.
- busy = (state != IDLE).

Test Plan:
- baud_div=1, OVERSAMPLE=16, no parity, one stop; drive 0xA5 with 16-clk bits -> rx_valid=1 with rx_data=0xA5, both error flags 0, busy low after stop.
- parity_en=1, parity_odd=0, send 0x07 with parity bit 1 -> parity_err=0. Same frame with parity bit 0 -> rx_parity_err=1, rx_data=0x07.
- Drive stop bit 0 for frame 0x3C -> rx_frame_err=1, rx_data=0x3C. stop_bits=1 with second stop bit 0 -> rx_frame_err=1.
- 4-clk low glitch on rx in IDLE (shorter than a half bit) -> returns to IDLE, no FIFO write, rx_valid stays 0.
- rx_ready=0, send 5 frames 0x01..0x05 with FIFO_DEPTH=4 -> one overrun pulse on the 5th frame. Pops then return 0x01, 0x02, 0x03, 0x04 in order, then rx_valid=0.
- Assert rst_n low mid-DATA of 0x55 -> busy=0 and rx_valid=0 immediately. After release, the next frame 0x66 is received correctly.
